// File: rtl/decode_stage.sv
// Decode stage: decodes a 16-bit instruction, reads an 8x16 register file and issues an operand bundle to execute.
// Latency: one cycle from fire (if_valid && id_ready) to ex_valid.
// Backpressure: id_ready drops on a RAW/WAW hazard in the busy scoreboard, or when execute has not taken the held bundle.
//
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   if_valid/if_pc/if_instr    fetch bundle in; id_ready (combinational) accepts it
//   wb_en/wb_rd/wb_data        writeback from the final stage (writes at posedge, bypassed to reads)
//   ex_ready                   execute can accept; ex_valid plus ex_* carry the registered bundle
//   perf_issue/perf_stall      saturating issue/stall counters, present only when DECODE_PERF_EN is defined
//
// Optional feature macro: DECODE_PERF_EN

module decode_stage #(
   parameter int  XLEN  = 16,
   parameter int  NREGS = 8,
   localparam int RIDX  = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_valid,
   input  logic [XLEN-1:0] if_pc,
   input  logic [XLEN-1:0] if_instr,
   output logic            id_ready,
   input  logic            wb_en,
   input  logic [RIDX-1:0] wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            ex_ready,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [3:0]      ex_alu_op,
   output logic [RIDX-1:0] ex_rd,
   output logic [XLEN-1:0] ex_rs1_val,
   output logic [XLEN-1:0] ex_rs2_val,
   output logic [XLEN-1:0] ex_imm,
   output logic            ex_wen,
   output logic            ex_illegal
`ifdef DECODE_PERF_EN
   ,
   output logic [15:0]     perf_issue,
   output logic [15:0]     perf_stall
`endif
);

   // Opcode map
   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LOADI = 4'h1;
   localparam logic [3:0] OP_ADD   = 4'h2;
   localparam logic [3:0] OP_XOR   = 4'h6;

   // Registered bundle toward execute
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [3:0]      alu_op;
      logic [RIDX-1:0] rd;
      logic [XLEN-1:0] rs1_val;
      logic [XLEN-1:0] rs2_val;
      logic [XLEN-1:0] imm;
      logic            wen;
      logic            illegal;
   } ex_bundle_t;

   // ------------------------------------------------------------------
   // Instruction field extraction
   // ------------------------------------------------------------------
   logic [3:0]      dec_op;
   logic [RIDX-1:0] dec_rd;
   logic [RIDX-1:0] dec_rs1;
   logic [RIDX-1:0] dec_rs2;
   logic [7:0]      dec_imm8;

   assign dec_op   = if_instr[15:12];
   assign dec_rd   = if_instr[11:9];
   assign dec_rs1  = if_instr[8:6];
   assign dec_rs2  = if_instr[5:3];
   assign dec_imm8 = if_instr[7:0];

   logic dec_is_alu;
   logic dec_is_loadi;
   logic dec_illegal;
   logic dec_wen;

   always_comb begin
      dec_is_alu   = (dec_op >= OP_ADD) && (dec_op <= OP_XOR);
      dec_is_loadi = (dec_op == OP_LOADI);
      dec_illegal  = (dec_op > OP_XOR);
      // NOP and illegal opcodes never write; writes to r0 are dropped here
      // so they neither set a busy bit nor reach execute as a write.
      dec_wen      = (dec_is_alu || dec_is_loadi) && (dec_rd != '0);
   end

   // ------------------------------------------------------------------
   // Register file with same-cycle writeback bypass
   // ------------------------------------------------------------------
   logic [XLEN-1:0] rf [NREGS];
   logic [XLEN-1:0] rs1_rd_val;
   logic [XLEN-1:0] rs2_rd_val;

   always_comb begin
      rs1_rd_val = '0;
      if (dec_rs1 != '0) begin
         if (wb_en && (wb_rd == dec_rs1)) rs1_rd_val = wb_data;
         else                             rs1_rd_val = rf[dec_rs1];
      end
   end

   always_comb begin
      rs2_rd_val = '0;
      if (dec_rs2 != '0) begin
         if (wb_en && (wb_rd == dec_rs2)) rs2_rd_val = wb_data;
         else                             rs2_rd_val = rf[dec_rs2];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else begin
         rf[0] <= '0;
         for (int i = 1; i < NREGS; i++) begin
            if (wb_en && (wb_rd == RIDX'(i))) rf[i] <= wb_data;
         end
      end
   end

   // ------------------------------------------------------------------
   // Busy scoreboard and hazard detection
   // ------------------------------------------------------------------
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] wb_clr;
   logic [NREGS-1:0] issue_set;
   logic [NREGS-1:0] eff_busy;
   logic [NREGS-1:0] busy_nxt;

   always_comb begin
      wb_clr = '0;
      if (wb_en) wb_clr[wb_rd] = 1'b1;
   end

   // A writeback landing this cycle releases its register immediately, so
   // a dependent instruction can issue in the same cycle using the bypass.
   assign eff_busy = busy & ~wb_clr;

   logic hazard;
   logic advance;
   logic fire;

   always_comb begin
      hazard = if_valid &&
               ((dec_is_alu && (eff_busy[dec_rs1] || eff_busy[dec_rs2])) ||
                (dec_wen && eff_busy[dec_rd]));
   end

   assign advance  = !ex_valid || ex_ready;
   assign id_ready = advance && !hazard;
   assign fire     = if_valid && id_ready;

   always_comb begin
      issue_set = '0;
      if (fire && dec_wen) issue_set[dec_rd] = 1'b1;
   end

   // Set after clear: a new writer issued in the same cycle as the old
   // writer's writeback keeps the register busy.
   always_comb begin
      busy_nxt    = (busy & ~wb_clr) | issue_set;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) busy <= '0;
      else       busy <= busy_nxt;
   end

   // ------------------------------------------------------------------
   // Output register toward execute
   // ------------------------------------------------------------------
   ex_bundle_t dec_bundle;
   ex_bundle_t ex_q;

   always_comb begin
      dec_bundle.pc      = if_pc;
      dec_bundle.alu_op  = dec_op;
      dec_bundle.rd      = dec_rd;
      // Only ALU ops consume sources; everything else presents zero operands.
      dec_bundle.rs1_val = dec_is_alu ? rs1_rd_val : '0;
      dec_bundle.rs2_val = dec_is_alu ? rs2_rd_val : '0;
      dec_bundle.imm     = {{(XLEN-8){1'b0}}, dec_imm8};
      dec_bundle.wen     = dec_wen;
      dec_bundle.illegal = dec_illegal;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid <= 1'b0;
         ex_q     <= '0;
      end else if (advance) begin
         // Without a fire the stage emits a bubble; payload is left as-is.
         ex_valid <= fire;
         if (fire) ex_q <= dec_bundle;
      end
   end

   assign ex_pc      = ex_q.pc;
   assign ex_alu_op  = ex_q.alu_op;
   assign ex_rd      = ex_q.rd;
   assign ex_rs1_val = ex_q.rs1_val;
   assign ex_rs2_val = ex_q.rs2_val;
   assign ex_imm     = ex_q.imm;
   assign ex_wen     = ex_q.wen;
   assign ex_illegal = ex_q.illegal;

`ifdef DECODE_PERF_EN
   // ------------------------------------------------------------------
   // Saturating performance counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_issue <= '0;
         perf_stall <= '0;
      end else begin
         if (fire && (perf_issue != 16'hFFFF))
            perf_issue <= perf_issue + 16'd1;
         // Backpressure from execute is not counted, only hazard stalls.
         if (hazard && (perf_stall != 16'hFFFF))
            perf_stall <= perf_stall + 16'd1;
      end
   end
`endif

   // NOP needs no decode of its own beyond "not ALU, not LOADI, not illegal".
   logic unused_nop;
   assign unused_nop = (dec_op == OP_NOP);

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: table of per-cycle vectors plus hand sequences for reset behaviour.
// Latency: bundle outputs checked one cycle after each applied row; id_ready checked within the cycle.
// Backpressure: ex_ready is driven per row to exercise hold behaviour.

module tb_decode_stage;

   logic        clk;
   logic        reset;
   logic        if_valid;
   logic [15:0] if_pc;
   logic [15:0] if_instr;
   logic        id_ready;
   logic        wb_en;
   logic [2:0]  wb_rd;
   logic [15:0] wb_data;
   logic        ex_ready;
   logic        ex_valid;
   logic [15:0] ex_pc;
   logic [3:0]  ex_alu_op;
   logic [2:0]  ex_rd;
   logic [15:0] ex_rs1_val;
   logic [15:0] ex_rs2_val;
   logic [15:0] ex_imm;
   logic        ex_wen;
   logic        ex_illegal;
`ifdef DECODE_PERF_EN
   logic [15:0] perf_issue;
   logic [15:0] perf_stall;
`endif

   decode_stage dut (
      .clk        (clk),
      .reset      (reset),
      .if_valid   (if_valid),
      .if_pc      (if_pc),
      .if_instr   (if_instr),
      .id_ready   (id_ready),
      .wb_en      (wb_en),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .ex_ready   (ex_ready),
      .ex_valid   (ex_valid),
      .ex_pc      (ex_pc),
      .ex_alu_op  (ex_alu_op),
      .ex_rd      (ex_rd),
      .ex_rs1_val (ex_rs1_val),
      .ex_rs2_val (ex_rs2_val),
      .ex_imm     (ex_imm),
      .ex_wen     (ex_wen),
      .ex_illegal (ex_illegal)
`ifdef DECODE_PERF_EN
      ,
      .perf_issue (perf_issue),
      .perf_stall (perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic chk_bundle(input string tag, input logic vld, input logic [15:0] pc,
                             input logic [3:0] op, input logic [2:0] rd,
                             input logic [15:0] rs1, input logic [15:0] rs2,
                             input logic [15:0] imm, input logic wen, input logic ill);
      chk({tag, " ex_valid"},   {15'd0, ex_valid},   {15'd0, vld});
      chk({tag, " ex_pc"},      ex_pc,               pc);
      chk({tag, " ex_alu_op"},  {12'd0, ex_alu_op},  {12'd0, op});
      chk({tag, " ex_rd"},      {13'd0, ex_rd},      {13'd0, rd});
      chk({tag, " ex_rs1_val"}, ex_rs1_val,          rs1);
      chk({tag, " ex_rs2_val"}, ex_rs2_val,          rs2);
      chk({tag, " ex_imm"},     ex_imm,              imm);
      chk({tag, " ex_wen"},     {15'd0, ex_wen},     {15'd0, wen});
      chk({tag, " ex_illegal"}, {15'd0, ex_illegal}, {15'd0, ill});
   endtask

   typedef struct packed {
      logic        ivld;
      logic [15:0] instr;
      logic [15:0] pc;
      logic        wben;
      logic [2:0]  wbrd;
      logic [15:0] wbdat;
      logic        exrdy;
      logic        e_idrdy;
      logic        e_vld;
      logic [15:0] e_pc;
      logic [3:0]  e_op;
      logic [2:0]  e_rd;
      logic [15:0] e_rs1;
      logic [15:0] e_rs2;
      logic [15:0] e_imm;
      logic        e_wen;
      logic        e_ill;
   } vec_t;

   vec_t tbl [16];

   initial begin
      // ivld instr     pc        wben wbrd wbdat     exrdy | idrdy vld pc        op    rd    rs1       rs2       imm       wen   ill
      tbl[0]  = '{1'b1, 16'h1210, 16'h0100, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0100, 4'h1, 3'd1, 16'h0000, 16'h0000, 16'h0010, 1'b1, 1'b0}; // LOADI r1,0x10
      tbl[1]  = '{1'b1, 16'h2650, 16'h0102, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0100, 4'h1, 3'd1, 16'h0000, 16'h0000, 16'h0010, 1'b1, 1'b0}; // ADD r3,r1,r2 RAW stall
      tbl[2]  = '{1'b1, 16'h2650, 16'h0102, 1'b1, 3'd1, 16'h0010, 1'b1, 1'b1, 1'b1, 16'h0102, 4'h2, 3'd3, 16'h0010, 16'h0000, 16'h0050, 1'b1, 1'b0}; // wb r1 -> bypass
      tbl[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 3'd2, 16'h0020, 1'b1, 1'b1, 1'b0, 16'h0102, 4'h2, 3'd3, 16'h0010, 16'h0000, 16'h0050, 1'b1, 1'b0}; // wb r2, idle
      tbl[4]  = '{1'b1, 16'h3888, 16'h0104, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0104, 4'h3, 3'd4, 16'h0020, 16'h0010, 16'h0088, 1'b1, 1'b0}; // SUB r4,r2,r1
      tbl[5]  = '{1'b1, 16'h6AD0, 16'h0106, 1'b1, 3'd3, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0104, 4'h3, 3'd4, 16'h0020, 16'h0010, 16'h0088, 1'b1, 1'b0}; // ex_ready=0, wb r3
      tbl[6]  = '{1'b1, 16'h6AD0, 16'h0106, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0104, 4'h3, 3'd4, 16'h0020, 16'h0010, 16'h0088, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 16'h6AD0, 16'h0106, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0104, 4'h3, 3'd4, 16'h0020, 16'h0010, 16'h0088, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 16'h6AD0, 16'h0106, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0106, 4'h6, 3'd5, 16'h0005, 16'h0020, 16'h00D0, 1'b1, 1'b0}; // XOR r5,r3,r2 issues
      tbl[9]  = '{1'b1, 16'hF940, 16'h0108, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0108, 4'hF, 3'd4, 16'h0000, 16'h0000, 16'h0040, 1'b0, 1'b1}; // illegal, busy regs ignored
      tbl[10] = '{1'b1, 16'h10FF, 16'h010A, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h010A, 4'h1, 3'd0, 16'h0000, 16'h0000, 16'h00FF, 1'b0, 1'b0}; // LOADI r0,0xFF
      tbl[11] = '{1'b1, 16'h2C08, 16'h010C, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h010C, 4'h2, 3'd6, 16'h0000, 16'h0010, 16'h0008, 1'b1, 1'b0}; // ADD r6,r0,r1
      tbl[12] = '{1'b1, 16'h5E00, 16'h010E, 1'b1, 3'd0, 16'hBEEF, 1'b1, 1'b1, 1'b1, 16'h010E, 4'h5, 3'd7, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0}; // OR r7,r0,r0, wb r0 not bypassed
      tbl[13] = '{1'b1, 16'h1C33, 16'h0110, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h010E, 4'h5, 3'd7, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0}; // LOADI r6 WAW stall
      tbl[14] = '{1'b1, 16'h1C33, 16'h0110, 1'b1, 3'd6, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h0110, 4'h1, 3'd6, 16'h0000, 16'h0000, 16'h0033, 1'b1, 1'b0}; // wb r6 frees it
      tbl[15] = '{1'b1, 16'h2380, 16'h0112, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0110, 4'h1, 3'd6, 16'h0000, 16'h0000, 16'h0033, 1'b1, 1'b0}; // set beats clear: r6 busy
   end

   initial begin
      reset    = 1'b1;
      if_valid = 1'b0;
      if_pc    = '0;
      if_instr = '0;
      wb_en    = 1'b0;
      wb_rd    = '0;
      wb_data  = '0;
      ex_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_bundle("reset", 1'b0, 16'h0, 4'h0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      if_valid = 1'b1;
      if_instr = 16'h2650;
      #1;
      chk("reset id_ready", {15'd0, id_ready}, 16'd1);
`ifdef DECODE_PERF_EN
      chk("reset perf_issue", perf_issue, 16'd0);
      chk("reset perf_stall", perf_stall, 16'd0);
`endif
      if_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Table-driven main sequence
      for (int i = 0; i < 16; i++) begin
         if_valid = tbl[i].ivld;
         if_instr = tbl[i].instr;
         if_pc    = tbl[i].pc;
         wb_en    = tbl[i].wben;
         wb_rd    = tbl[i].wbrd;
         wb_data  = tbl[i].wbdat;
         ex_ready = tbl[i].exrdy;
         #2;
         chk($sformatf("row%0d id_ready", i), {15'd0, id_ready}, {15'd0, tbl[i].e_idrdy});
         @(posedge clk);
         #1;
         chk_bundle($sformatf("row%0d", i), tbl[i].e_vld, tbl[i].e_pc, tbl[i].e_op, tbl[i].e_rd,
                    tbl[i].e_rs1, tbl[i].e_rs2, tbl[i].e_imm, tbl[i].e_wen, tbl[i].e_ill);
      end
`ifdef DECODE_PERF_EN
      chk("perf_issue count", perf_issue, 16'd9);
      chk("perf_stall count", perf_stall, 16'd3);
`endif

      // Reset mid-stall with ex_valid held high
      if_valid = 1'b1;
      if_instr = 16'h1401;               // LOADI r2,0x01
      if_pc    = 16'h0200;
      wb_en    = 1'b0;
      ex_ready = 1'b1;
      #2;
      chk("pre-rst id_ready", {15'd0, id_ready}, 16'd1);
      @(posedge clk);
      #1;
      chk("pre-rst ex_valid", {15'd0, ex_valid}, 16'd1);
      if_instr = 16'h2380;               // ADD r1,r6,r0, r6 still busy
      if_pc    = 16'h0202;
      ex_ready = 1'b0;
      #2;
      chk("stall id_ready", {15'd0, id_ready}, 16'd0);
      @(posedge clk);
      #1;
      chk("stall ex_valid hold", {15'd0, ex_valid}, 16'd1);
      chk("stall ex_rd hold", {13'd0, ex_rd}, 16'd2);
      #2;
      reset = 1'b1;
      #1;
      chk_bundle("async rst", 1'b0, 16'h0, 4'h0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      chk("async rst id_ready", {15'd0, id_ready}, 16'd1);
`ifdef DECODE_PERF_EN
      chk("async rst perf_issue", perf_issue, 16'd0);
      chk("async rst perf_stall", perf_stall, 16'd0);
`endif
      @(posedge clk);
      #1;
      reset    = 1'b0;
      ex_ready = 1'b1;
      #2;
      chk("post-rst id_ready", {15'd0, id_ready}, 16'd1);
      @(posedge clk);
      #1;
      chk_bundle("post-rst", 1'b1, 16'h0202, 4'h2, 3'd1, 16'h0000, 16'h0000, 16'h0080, 1'b1, 1'b0);

      // Writeback after reset still updates the register file
      if_valid = 1'b0;
      wb_en    = 1'b1;
      wb_rd    = 3'd6;
      wb_data  = 16'h0077;
      @(posedge clk);
      #1;
      wb_en    = 1'b0;
      if_valid = 1'b1;
      if_instr = 16'h2780;               // ADD r3,r6,r0
      if_pc    = 16'h0204;
      #2;
      chk("wb-after-rst id_ready", {15'd0, id_ready}, 16'd1);
      @(posedge clk);
      #1;
      chk_bundle("wb-after-rst", 1'b1, 16'h0204, 4'h2, 3'd3, 16'h0077, 16'h0000, 16'h0080, 1'b1, 1'b0);
      if_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second stage of the 4-stage pipeline, between fetch and execute.
- Decodes the 16-bit instruction, reads operands from an 8x16 register file, and accepts writebacks from the final stage.
- Stalls fetch on RAW/WAW hazards using a per-register busy scoreboard.
- Presents a registered operand bundle to execute over a valid/ready handshake.

Parameters:
- XLEN, 16, datapath and instruction width.
- NREGS, 8, register count; index width is 3 bits; r0 reads as 0 and is never written.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- if_valid  input  1  fetch bundle valid.
- if_pc  input  16  PC of the fetched instruction.
- if_instr  input  16  fetched instruction.
- id_ready  output  1  decode accepts the fetch bundle this cycle (combinational).
- wb_en  input  1  writeback strobe.
- wb_rd  input  3  writeback register index.
- wb_data  input  16  writeback data.
- ex_ready  input  1  execute can accept a bundle.
- ex_valid  output  1  bundle valid toward execute.
- ex_pc  output  16  PC of the issued instruction.
- ex_alu_op  output  4  opcode passed through.
- ex_rd  output  3  destination register.
- ex_rs1_val  output  16  operand 1.
- ex_rs2_val  output  16  operand 2.
- ex_imm  output  16  zero-extended imm8.
- ex_wen  output  1  instruction writes rd.
- ex_illegal  output  1  undefined opcode flag.

Behaviour:
- Format: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm8.
- Opcodes:
  - 0 NOP.
  - 1 LOADI: rd = zext(imm8).
  - 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR: rd = rs1 op rs2.
  - 7-F illegal.
- Illegal instructions issue with ex_illegal=1 and ex_wen=0. They create no hazard and read no sources.
- ex_wen = 1 for opcodes 1-6 with rd != 0; otherwise 0.
- Sources used: ALU ops use rs1 and rs2; LOADI and NOP use none.
- Register file:
  - Write at posedge when wb_en and wb_rd != 0.
  - Reads are combinational with same-cycle bypass: if wb_en && wb_rd == rsX && rsX != 0, wb_data is forwarded.
- Scoreboard busy[7:0]:
  - Effective busy = busy & ~(wb_en ? onehot(wb_rd) : 0).
  - hazard = if_valid && ((used rs1 effbusy) || (used rs2 effbusy) || (ex_wen-candidate rd effbusy)).
  - WAW stalls too, so each register has at most one pending writer.
- advance = !ex_valid || ex_ready.
- id_ready = advance && !hazard.
- fire = if_valid && id_ready.
- Output register update on advance:
  - fire: load the bundle, ex_valid <= 1.
  - no fire: ex_valid <= 0 (bubble); other ex_* hold their previous values.
- Not advance: all ex_* hold.
- Scoreboard update each cycle:
  - Clear the bit for wb_rd on wb_en.
  - Set the bit for rd on fire with write enable.
  - Set wins over clear for the same index.
  - Bit 0 is always 0.
- Latency: 1 cycle from fire to ex_valid.
- Stall: while hazard, id_ready = 0 and fetch must hold if_pc/if_instr.
- Reset (async, any time including mid-stall):
  - ex_valid and all ex_* = 0.
  - All registers = 0; busy = 0.
  - id_ready then follows combinational rules.
- A wb_en arriving after reset still writes the register file; the busy clear is a no-op.

Optional Feature:
- Macro: DECODE_PERF_EN.
- Defined: adds outputs perf_issue[15:0] and perf_stall[15:0].
  - perf_issue increments on fire.
  - perf_stall increments on cycles with if_valid && hazard.
  - Both are saturating at 0xFFFF, reset to 0.
- Undefined: neither port nor either counter exists; behaviour is otherwise identical.

Test Plan:
- Reset, then LOADI r1,0x10 (0x1210) with ex_ready=1 -> next cycle ex_valid=1, ex_alu_op=1, ex_rd=1, ex_imm=0x0010, ex_wen=1, busy[1]=1.
- Issue LOADI r1, then ADD r3,r1,r2 (0x2650) while no writeback -> id_ready=0, ex_valid drops to 0 (bubble), perf_stall counts. Then wb_en=1, wb_rd=1, wb_data=0x0010 -> same cycle id_ready=1; next cycle ex_rs1_val=0x0010 via bypass.
- Write r2=0x0020 via wb; SUB r4,r2,r1 (0x3888) with r1=0x0010 -> ex_rs1_val=0x0020, ex_rs2_val=0x0010, ex_rd=4.
- ex_ready=0 for 3 cycles with ex_valid=1 -> all ex_* stable, id_ready=0. Release -> next bundle issues one cycle later.
- Opcode 0xF000 -> ex_illegal=1, ex_wen=0, no busy bit set. LOADI r0,0xFF -> ex_wen=0, r0 reads 0.
- Assert reset mid-stall with busy[1]=1 -> busy=0, ex_valid=0 immediately; first instruction after deassert issues without stall.
